// File: rtl/if_id_stage.sv
// Elastic IF/ID boundary: DEPTH-entry instruction queue with valid/ready on both sides.
// Optional decode-bubble counter enabled by defining IF_ID_BUBBLE_COUNT_EN.
module if_id_stage #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InInstr,
    input  logic [31:0] InPCPlus4,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic [31:0] OutPCPlus4,
    output logic [15:0] OutImm,
    output logic        OutSignExt
`ifdef IF_ID_BUBBLE_COUNT_EN
    ,
    output logic [31:0] BubbleCount
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // Flop-based storage: the head must be visible combinationally from rd_ptr.
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic [DEPTH-1:0] slot_we;

    logic push;
    logic pop;
    logic [31:0] head_instr;
    logic [31:0] head_pc;

    assign InReady  = (count_reg < CNT_W'(DEPTH));
    assign OutValid = (count_reg != '0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && !Flush && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                instr_mem[i] <= InInstr;
                pc_mem[i]    <= InPCPlus4;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head_instr = instr_mem[rd_ptr_reg];
    assign head_pc    = pc_mem[rd_ptr_reg];

    // An empty queue presents a NOP so decode sees harmless, sign-extending zeros.
    assign OutInstr   = OutValid ? head_instr : 32'h0;
    assign OutPCPlus4 = OutValid ? head_pc : 32'h0;
    assign OutImm     = OutInstr[15:0];
    // ANDI/ORI/XORI/LUI (opcodes 0x0C..0x0F) zero-extend their immediate.
    assign OutSignExt = (OutInstr[31:28] != 4'b0011);

`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [31:0] bubble_count_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bubble_count_reg <= '0;
        end else if (OutReady && !OutValid && (bubble_count_reg != 32'hFFFF_FFFF)) begin
            bubble_count_reg <= bubble_count_reg + 32'd1;
        end
    end

    assign BubbleCount = bubble_count_reg;
`endif

endmodule
